// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared types and sizing helpers for the byte-enable scratch memory
package memory_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Number of words addressed by a given word-address width.
  function automatic int depth_of(input int address_width);
    return 1 << address_width;
  endfunction

  // Number of byte lanes in a word.
  function automatic int lanes_of(input int data_width);
    return data_width / 8;
  endfunction

  // Only one or two read register stages are supported.
  function automatic bit read_latency_ok(input int read_latency);
    return (read_latency == 1) || (read_latency == 2);
  endfunction

endpackage

// File: rtl/memory_read_pipe.sv
// rtl/memory_read_pipe.sv - one or two stage {valid, data} delay line for read results
module memory_read_pipe
  import memory_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data
);

  logic [STAGES-1:0]                 valid_q;
  logic [STAGES-1:0][DATA_WIDTH-1:0] data_q;

  // Shift the valid bit every cycle; data only moves with a valid so the last stage holds the previous result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q[0] <= req_valid;
      if (req_valid) data_q[0] <= req_data;
      for (int s = 1; s < STAGES; s++) begin
        valid_q[s] <= valid_q[s-1];
        if (valid_q[s-1]) data_q[s] <= data_q[s-1];
      end
    end
  end

  assign rsp_valid = valid_q[STAGES-1];
  assign rsp_data  = data_q[STAGES-1];

endmodule

// File: rtl/memory_be_ctrl.sv
// rtl/memory_be_ctrl.sv - single-port scratch RAM with byte enables, read latency and clear engine
module memory_be_ctrl
  import memory_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 4,
  parameter int READ_LATENCY  = 1,
  parameter int INIT_CLEAR    = 1
) (
  input  logic                     iClk,
  input  logic                     iReset_n,
  input  logic                     iChipSelect_n,
  input  logic                     iRead_n,
  input  logic                     iWrite_n,
  input  logic [DATA_WIDTH/8-1:0]  iByteEn_n,
  input  logic [ADDRESS_WIDTH-1:0] iAddress,
  input  logic [DATA_WIDTH-1:0]    iData,
  input  logic                     iClear,
  output logic [DATA_WIDTH-1:0]    oData,
  output logic                     oValid,
  output logic                     oBusy,
  output logic                     oDrop
);

  localparam int     DEPTH       = depth_of(ADDRESS_WIDTH);
  localparam int     LANES       = lanes_of(DATA_WIDTH);
  localparam state_t RESET_STATE = (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;

  if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
    $error("memory_be_ctrl: READ_LATENCY must be 1 or 2");
  end

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] clr_cnt;
  logic                     drop_q;
  logic [DATA_WIDTH-1:0]    mem [DEPTH];

  logic busy;
  logic clear_take;
  logic wr_req;
  logic rd_req;
  logic wr_ok;
  logic rd_ok;
  logic refuse;

  // A write with every lane disabled is not an access at all, so it can never be dropped.
  assign busy       = (state == ST_CLEAR);
  assign clear_take = ~busy & iClear;
  assign wr_req     = ~iChipSelect_n & ~iWrite_n & ~(&iByteEn_n);
  assign rd_req     = ~iChipSelect_n & ~iRead_n;
  assign wr_ok      = wr_req & ~busy & ~clear_take;
  assign rd_ok      = rd_req & ~busy & ~clear_take;
  assign refuse     = (wr_req | rd_req) & (busy | clear_take);

  // Clear FSM walks the counter over every word once; refused accesses are flagged a cycle later.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state   <= RESET_STATE;
      clr_cnt <= '0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= refuse;
      case (state)
        ST_CLEAR: begin
          if (&clr_cnt) begin
            state   <= ST_READY;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + ADDRESS_WIDTH'(1);
          end
        end
        ST_READY: begin
          if (iClear) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end
        end
        default: state <= RESET_STATE;
      endcase
    end
  end

  // Array update: the clear engine owns the port while busy, otherwise enabled byte lanes are written.
  always_ff @(posedge iClk) begin
    if (busy) begin
      mem[clr_cnt] <= '0;
    end else if (wr_ok) begin
      for (int k = 0; k < LANES; k++) begin
        if (!iByteEn_n[k]) mem[iAddress][8*k +: 8] <= iData[8*k +: 8];
      end
    end
  end

  // The array is sampled in the request cycle, so a same-cycle write is seen only by later reads.
  memory_read_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .STAGES     (READ_LATENCY)
  ) u_read_pipe (
    .clk       (iClk),
    .rst_n     (iReset_n),
    .req_valid (rd_ok),
    .req_data  (mem[iAddress]),
    .rsp_valid (oValid),
    .rsp_data  (oData)
  );

  assign oBusy = busy;
  assign oDrop = drop_q;

endmodule

// File: tb/tb_memory_be_ctrl.sv
// tb/tb_memory_be_ctrl.sv - scoreboard bench driving latency-1 and latency-2 instances in lockstep
module tb_memory_be_ctrl;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rd_item_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_n  = 1'b1;
  logic        rd_n  = 1'b1;
  logic        wr_n  = 1'b1;
  logic        clr   = 1'b0;
  logic [3:0]  be_n  = 4'hF;
  logic [3:0]  addr  = 4'h0;
  logic [31:0] wdata = 32'h0;

  logic [31:0] data0, data1;
  logic        valid0, valid1, busy0, busy1, drop0, drop1;
  logic [1:0]  valid_v, busy_v, drop_v;
  logic [31:0] data_v [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_busy;
  int pre_busy;

  rd_item_t rdq   [2][$];
  int       dropq [2][$];

  assign valid_v   = {valid1, valid0};
  assign busy_v    = {busy1, busy0};
  assign drop_v    = {drop1, drop0};
  assign data_v[0] = data0;
  assign data_v[1] = data1;

  memory_be_ctrl #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(4), .READ_LATENCY(1), .INIT_CLEAR(1)
  ) u_lat1 (
    .iClk(clk), .iReset_n(rst_n), .iChipSelect_n(cs_n), .iRead_n(rd_n), .iWrite_n(wr_n),
    .iByteEn_n(be_n), .iAddress(addr), .iData(wdata), .iClear(clr),
    .oData(data0), .oValid(valid0), .oBusy(busy0), .oDrop(drop0)
  );

  memory_be_ctrl #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(4), .READ_LATENCY(2), .INIT_CLEAR(1)
  ) u_lat2 (
    .iClk(clk), .iReset_n(rst_n), .iChipSelect_n(cs_n), .iRead_n(rd_n), .iWrite_n(wr_n),
    .iByteEn_n(be_n), .iAddress(addr), .iData(wdata), .iClear(clr),
    .oData(data1), .oValid(valid1), .oBusy(busy1), .oDrop(drop1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expected read results and drop pulses, checking value and arrival cycle.
  always @(negedge clk) begin
    rd_item_t it;
    for (int i = 0; i < 2; i++) begin
      if (valid_v[i]) begin
        checks++;
        if (rdq[i].size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid inst=%0d cyc=%0d got=%h required=no_result", i, cyc, data_v[i]);
        end else begin
          it = rdq[i].pop_front();
          if (it.due != cyc || data_v[i] !== it.data) begin
            failures++;
            $display("FAIL read inst=%0d got=%h@%0d required=%h@%0d", i, data_v[i], cyc, it.data, it.due);
          end
        end
      end else if (rdq[i].size() != 0 && rdq[i][0].due <= cyc) begin
        checks++;
        failures++;
        it = rdq[i].pop_front();
        $display("FAIL missing_read inst=%0d cyc=%0d got=no_valid required=%h@%0d", i, cyc, it.data, it.due);
      end
      if (drop_v[i]) begin
        checks++;
        if (dropq[i].size() == 0 || dropq[i][0] != cyc) begin
          failures++;
          $display("FAIL unexpected_drop inst=%0d cyc=%0d got=1 required=0", i, cyc);
        end
        if (dropq[i].size() != 0) void'(dropq[i].pop_front());
      end else if (dropq[i].size() != 0 && dropq[i][0] <= cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_drop inst=%0d cyc=%0d got=0 required=1@%0d", i, cyc, dropq[i][0]);
        void'(dropq[i].pop_front());
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  task automatic access(input logic rd, input logic wr, input logic [3:0] be, input logic [3:0] a,
                        input logic [31:0] d, input logic [31:0] exp, input logic exp_drop,
                        input logic clear_req);
    rd_item_t it;
    @(negedge clk);
    cs_n  = ~(rd | wr);
    rd_n  = ~rd;
    wr_n  = ~wr;
    be_n  = be;
    addr  = a;
    wdata = d;
    clr   = clear_req;
    for (int i = 0; i < 2; i++) begin
      if (exp_drop) begin
        dropq[i].push_back(cyc + 1);
      end else if (rd) begin
        it.data = exp;
        it.due  = cyc + i + 1;
        rdq[i].push_back(it);
      end
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    access(1'b0, 1'b1, be, a, d, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp);
    access(1'b1, 1'b0, 4'hF, a, 32'h0, exp, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) access(1'b0, 1'b0, 4'hF, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // Counts consecutive negedges (starting with the current one) on which the engine is busy.
  task automatic count_busy(output int n);
    n = 0;
    while (busy_v[0] && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_data0"}, data0, 32'h0);
    chk({tag, "_data1"}, data1, 32'h0);
    chk({tag, "_valid"}, {30'd0, valid_v}, 32'h0);
    chk({tag, "_drop"},  {30'd0, drop_v}, 32'h0);
    chk({tag, "_busy"},  {30'd0, busy_v}, 32'h3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Power-on reset and initial clear.
    repeat (2) @(negedge clk);
    #1;
    chk_reset_state("por");
    @(negedge clk);
    rst_n = 1'b1;
    count_busy(n_busy);
    chk("init_busy_cycles", n_busy, 32'd16);
    for (int a = 0; a < 16; a++) rd(4'(a), 32'h0);
    idle(3);

    // Byte-lane merge and all-lanes-disabled no-op.
    wr(4'd3, 32'hAABBCCDD, 4'b0000);
    wr(4'd3, 32'h11223344, 4'b1010);
    wr(4'd3, 32'hFFFFFFFF, 4'b1111);
    rd(4'd3, 32'hAA22CC44);
    idle(3);

    // Back-to-back pipelined reads.
    wr(4'd1, 32'h1, 4'b0000);
    wr(4'd2, 32'h2, 4'b0000);
    wr(4'd3, 32'h3, 4'b0000);
    rd(4'd1, 32'h1);
    rd(4'd2, 32'h2);
    rd(4'd3, 32'h3);
    idle(4);

    // Read-before-write on the same address.
    wr(4'd5, 32'h5, 4'b0000);
    access(1'b1, 1'b1, 4'b0000, 4'd5, 32'h9, 32'h5, 1'b0, 1'b0);
    rd(4'd5, 32'h9);
    idle(3);

    // Clear request: same-cycle read refused, later write refused, oData held across clear.
    wr(4'd7, 32'h77, 4'b0000);
    rd(4'd7, 32'h77);
    idle(3);
    access(1'b1, 1'b0, 4'hF, 4'd0, 32'h0, 32'h0, 1'b1, 1'b1);
    idle(1);
    pre_busy = int'(busy_v[0]);
    access(1'b0, 1'b1, 4'b0000, 4'd7, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0);
    pre_busy += int'(busy_v[0]);
    idle(1);
    count_busy(n_busy);
    chk("clear_busy_cycles", pre_busy + n_busy, 32'd16);
    chk("hold_data0", data0, 32'h77);
    chk("hold_data1", data1, 32'h77);
    rd(4'd7, 32'h0);
    wr(4'd3, 32'h33, 4'b0000);
    rd(4'd3, 32'h33);
    idle(3);

    // Reset in the middle of a clear restarts it from address 0.
    access(1'b0, 1'b0, 4'hF, 4'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    idle(1);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_state("midclear_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_busy(n_busy);
    chk("restart_busy_cycles", n_busy, 32'd16);
    rd(4'd3, 32'h0);
    rd(4'd5, 32'h0);
    idle(4);

    chk("rdq0_empty", rdq[0].size(), 32'd0);
    chk("rdq1_empty", rdq[1].size(), 32'd0);
    chk("dropq_empty", dropq[0].size() + dropq[1].size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_be_ctrl.md
Name: memory_be_ctrl

Overview:
Parametrised single-port synchronous memory for the SoC bus. It is the next generation of the basic chip-select/read/write memory and adds:
- per-byte write enables;
- configurable read latency with a read-valid strobe;
- a hardware clear engine that zeroes the array after reset or on request;
- a busy/drop indication.

It sits behind the bus slave decoder as a local scratch RAM or register file.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDRESS_WIDTH, 4, word address bits; DEPTH = 2**ADDRESS_WIDTH words.
- READ_LATENCY, 1, cycles from read request to oValid; legal values 1 or 2.
- INIT_CLEAR, 1, 1 = run the clear engine after every reset; 0 = leave contents undefined and go straight to READY.

Ports:
- iClk  input  1  system clock; all state changes on the rising edge.
- iReset_n  input  1  asynchronous active-low reset.
- iChipSelect_n  input  1  active-low access select.
- iRead_n  input  1  active-low read request; qualified by iChipSelect_n.
- iWrite_n  input  1  active-low write request; qualified by iChipSelect_n.
- iByteEn_n  input  DATA_WIDTH/8  active-low byte-lane write enables; bit k covers iData[8k+7:8k].
- iAddress  input  ADDRESS_WIDTH  word address.
- iData  input  DATA_WIDTH  write data.
- iClear  input  1  single-cycle request to zero the whole array.
- oData  output  DATA_WIDTH  read data; holds its value between reads.
- oValid  output  1  one-cycle pulse when oData carries a new read result.
- oBusy  output  1  high while the clear engine runs; accesses are refused.
- oDrop  output  1  one-cycle pulse, one cycle after an access is refused.

Behaviour:
- Reset (asynchronous, iReset_n low):
  - oData=0, oValid=0, oDrop=0, read pipeline flushed, clear counter=0.
  - State goes to CLEAR (oBusy=1) if INIT_CLEAR=1; otherwise to READY (oBusy=0).
  - A reset in the middle of a clear restarts the clear from address 0.
- States: CLEAR, READY.
- CLEAR:
  - Each cycle writes 0 to mem[cnt], then cnt++.
  - After the write of address DEPTH-1 the state goes to READY. The clear takes exactly DEPTH cycles, and oBusy falls on the edge that completes the last write.
- READY:
  - iClear=1 goes to CLEAR with cnt=0. iClear has priority over any access in the same cycle; that access is refused.
- Access definitions:
  - Write = ~iChipSelect_n & ~iWrite_n.
  - Read = ~iChipSelect_n & ~iRead_n.
  - Both may be asserted in the same cycle.
- Refused access: any read or write while oBusy=1, or in a cycle where iClear is taken.
  - No array change and no oValid.
  - oDrop=1 on the next cycle.
  - The requester must retry.
- Write:
  - At the edge, for every lane k with iByteEn_n[k]=0, mem[iAddress] lane k <= iData lane k. Other lanes are unchanged.
  - All lanes disabled = no-op and not a drop.
- Read:
  - READ_LATENCY=1: oData <= mem[iAddress] and oValid=1 on the edge after the request.
  - READ_LATENCY=2: one extra register stage; data and oValid appear one cycle later.
  - Back-to-back reads are fully pipelined, one result per cycle, in order.
- Simultaneous read and write to the same address: the read returns the OLD word (read-before-write). The new value is visible to the next read.
- Address wrap: addresses are exactly ADDRESS_WIDTH bits, so there is no out-of-range case.
- oData is never cleared except by reset. It holds the last read result, including across a clear.
- In-flight reads that were accepted before a clear began still complete with their captured data.

Decomposition:
- Package memory_pkg:
  - state encoding (CLEAR, READY);
  - localparams DEPTH = 1<<ADDRESS_WIDTH and LANES = DATA_WIDTH/8;
  - READ_LATENCY legality check.
- Sub-module memory_read_pipe:
  - parametrised delay line (1 or 2 stages) carrying {valid, data};
  - asynchronous active-low reset flushes valid to 0 and data to 0.
- Top level holds the array, byte-lane write logic, clear FSM/counter and drop logic.

Test Plan:
1. Reset with INIT_CLEAR=1 (32-bit data, ADDRESS_WIDTH=4) -> oBusy high for exactly 16 cycles; afterwards reads of addresses 0..15 all return 0x00000000 with oValid pulsing.
2. Write 0xAABBCCDD to address 3 with iByteEn_n=4'b0000, then write 0x11223344 to address 3 with iByteEn_n=4'b1010 -> read of address 3 returns 0xAA22CC44.
3. READ_LATENCY=2 with reads of addresses 1, 2, 3 on consecutive cycles (contents 0x1, 0x2, 0x3) -> oValid high on cycles +2, +3, +4 with oData 0x1, 0x2, 0x3.
4. Address 5 holds 0x5; in one cycle, read and write address 5 with 0x9 -> that read returns 0x5; the next read returns 0x9.
5. Pulse iClear, then issue a write to address 7 two cycles later -> write refused, oDrop pulses one cycle later, oBusy high for 16 cycles; afterwards address 7 reads 0x0.
6. Assert iReset_n low at clear count 8, hold 2 cycles, release -> clear restarts from 0, oBusy high for a full 16 cycles after release, oValid=0 throughout.
